// File: rtl/divide_recombine.sv
// Rebuilds a dividend N = Q*D + R by shift-add, one multiplier bit per clock.
// Latency: start accepted at edge k, N/ovf valid at edge k+8, done pulses for one cycle after that.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module divide_recombine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  Q,
    input  logic [7:0]  D,
    input  logic [7:0]  R,
    output logic [15:0] N,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [2:0]  cnt;
    logic [15:0] sum;

    // 255*255 + 255 fits in 16 bits, so the accumulator never needs a carry out
    always_comb begin
        sum = acc + (mplier[0] ? mcand : 16'd0);
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= 16'd0;
            mcand  <= 16'd0;
            mplier <= 8'd0;
            cnt    <= 3'd0;
            N      <= 16'd0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= {8'd0, R};
                        mcand  <= {8'd0, D};
                        mplier <= Q;
                        cnt    <= 3'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    // Fixed 8-step latency even when operands are zero
                    if (cnt == 3'd7) begin
                        N     <= sum;
                        ovf   <= |sum[15:8];
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide_recombine.sv
// Self-checking bench for divide_recombine: scoreboard of expected {ovf, N} popped on each done pulse.
module tb_divide_recombine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  Q;
    logic [7:0]  D;
    logic [7:0]  R;
    logic [15:0] N;
    logic        busy;
    logic        done;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [16:0] exp_q[$];
    logic [15:0] prev_n;
    logic        prev_done;

    divide_recombine dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Q     (Q),
        .D     (D),
        .R     (R),
        .N     (N),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r);
        logic [15:0] n;
        n = 16'(q) * 16'(d) + 16'(r);
        return {(n > 16'd255), n};
    endfunction

    // Scoreboard and output-stability monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("result_n", 32'(N), 32'(e[15:0]));
                check("result_ovf", 32'(ovf), 32'(e[16]));
            end
            if (prev_done === 1'b1) check("done_twice", 32'd1, 32'd0);
        end else if (busy === 1'b1) begin
            check("n_stable", 32'(N), 32'(prev_n));
        end
        prev_n    = N;
        prev_done = done;
    end

    task automatic launch(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r);
        @(negedge clk);
        Q = q; D = d; R = r; start = 1'b1;
        exp_q.push_back(model(q, d, r));
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_on", 32'(busy), 32'd1);
    endtask

    // Count edges after the accept edge until done is seen; done must appear after edge k+8
    task automatic wait_done(input string tag);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) got = 1'b1;
        end
        check(tag, 32'(n), 32'd8);
        @(posedge clk);
        #1;
        check("busy_off", 32'(busy), 32'd0);
        check("done_off", 32'(done), 32'd0);
    endtask

    task automatic run_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r, input string tag);
        launch(q, d, r);
        wait_done(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; Q = 8'd0; D = 8'd0; R = 8'd0;
        prev_n = 16'd0; prev_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_n", 32'(N), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd2, 8'd5, 8'd0, "lat_roundtrip");
        run_op(8'd3, 8'd7, 8'd2, "lat_general");
        run_op(8'd25, 8'd10, 8'd5, "lat_fit255");
        run_op(8'd200, 8'd0, 8'd9, "lat_d_zero");
        run_op(8'd0, 8'd77, 8'd0, "lat_q_zero");
        run_op(8'd255, 8'd255, 8'd255, "lat_max");
        run_op(8'd16, 8'd16, 8'd0, "lat_256");

        // Abort after 4 RUN edges: no result expected, outputs cleared
        @(negedge clk);
        Q = 8'd5; D = 8'd5; R = 8'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_n", 32'(N), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (12) @(posedge clk);
        run_op(8'd4, 8'd4, 8'd3, "lat_after_abort");

        // Operand changes and a start pulse during RUN must be ignored
        launch(8'd6, 8'd6, 8'd0);
        begin
            int n;
            bit got;
            n = 0;
            got = 1'b0;
            while (!got && n < 30) begin
                @(posedge clk);
                #1;
                n++;
                if (n == 3) begin Q = 8'd9; D = 8'd9; R = 8'd9; start = 1'b1; end
                if (n == 4) start = 1'b0;
                if (done === 1'b1) got = 1'b1;
            end
            check("lat_stable", 32'(n), 32'd8);
        end
        repeat (14) @(posedge clk);
        #1;
        check("stable_idle", 32'(busy), 32'd0);

        // start held high: one result every 10 cycles, each with its own operands
        begin
            logic [7:0] tq[3];
            logic [7:0] td[3];
            logic [7:0] tr[3];
            int last_done;
            tq = '{8'd10, 8'd200, 8'd1};
            td = '{8'd20, 8'd3, 8'd1};
            tr = '{8'd30, 8'd7, 8'd255};
            last_done = 0;
            @(negedge clk);
            Q = tq[0]; D = td[0]; R = tr[0]; start = 1'b1;
            exp_q.push_back(model(tq[0], td[0], tr[0]));
            for (int i = 0; i < 3; i++) begin
                int n;
                bit got;
                n = 0;
                got = 1'b0;
                while (!got && n < 30) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (done === 1'b1) got = 1'b1;
                end
                check("b2b_seen", 32'(got), 32'd1);
                if (i > 0) check("b2b_period", 32'(cyc - last_done), 32'd10);
                last_done = cyc;
                if (i < 2) begin
                    @(posedge clk);
                    @(negedge clk);
                    Q = tq[i+1]; D = td[i+1]; R = tr[i+1];
                    exp_q.push_back(model(tq[i+1], td[i+1], tr[i+1]));
                end else begin
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
        repeat (15) @(posedge clk);
        #1;
        check("final_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
